axi4_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AXI4-Lite write and read transactions.
- Used by test harnesses and on-chip controllers to program the team's AXI4-Lite slave and its 4x32 register file, i.e. the other end of the slave interface.
- Handles one transaction at a time. Write address (AW) and write data (W) channels are issued concurrently.

---
 rtl/axi4_lite_defs.sv | 18 +
 rtl/dff_async_rst_n.sv | 27 ++
 rtl/axi4_lite_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_defs.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state set.
package axi4_lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ_ADDR,
    ST_READ_DATA,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dff_async_rst_n.sv
// Enable-capture register with asynchronous active-low reset.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, loads RESET_VALUE
//   en_i    load enable
//   d_i     next value
//   q_o     registered value
module dff_async_rst_n #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= RESET_VALUE;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator. Converts a command/response
// handshake into one AXI4-Lite write (AW+W issued together, then B) or
// read (AR, then R) at a time. All AXI and response outputs are registered.
// Ports:
//   i_clock, i_aresetn                 clock, async active-low reset
//   i_cmd_* / o_cmd_ready              command request (accepted in IDLE)
//   o_rsp_* / i_rsp_ready              response, held until consumed
//   o_aw*/i_awready, o_w*/i_wready     write address / write data channels
//   i_b*/o_bready                      write response channel
//   o_ar*/i_arready, i_r*/o_rready     read address / read data channels
module axi4_lite_master
  import axi4_lite_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                    i_clock,
  input  logic                    i_aresetn,
  // command
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
  // response
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]              o_rsp_resp,
  // AW
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [2:0]              o_awprot,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  // W
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  // B
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  // AR
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic [2:0]              o_arprot,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  // R
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic arvalid_q, arvalid_d;
  logic bready_q, bready_d;
  logic rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic cmd_ready_q, cmd_ready_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic                  cmd_capture;
  logic                  rsp_capture;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [1:0]            rsp_resp_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & i_awready;
  assign w_hs  = wvalid_q  & i_wready;
  assign ar_hs = arvalid_q & i_arready;
  assign b_hs  = bready_q  & i_bvalid;
  assign r_hs  = rready_q  & i_rvalid;

  // Word-align the command address; the whole port is read so no bit is left dangling.
  always_comb begin
    addr_aligned      = i_cmd_addr;
    addr_aligned[1:0] = 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cmd_capture = 1'b0;
    rsp_capture = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_resp_d  = RESP_OKAY;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_capture = 1'b1;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (i_cmd_write) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_READ_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      // Each channel drops its valid on its own handshake; the flags let the
      // two handshakes land in either order or in the same cycle.
      ST_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = ST_WRITE_RESP;
          bready_d = 1'b1;
        end
      end

      ST_WRITE_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_capture = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = i_bresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_READ_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_READ_DATA;
        end
      end

      ST_READ_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_capture = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = i_rdata;
          rsp_resp_d  = i_rresp;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered copy of "next state is IDLE" so o_cmd_ready is a flop output.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  dff_async_rst_n #(.WIDTH(ADDR_WIDTH)) u_addr_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(cmd_capture),
    .d_i   (addr_aligned), .q_o(addr_q)
  );

  dff_async_rst_n #(.WIDTH(DATA_WIDTH)) u_wdata_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(cmd_capture),
    .d_i   (i_cmd_wdata), .q_o(wdata_q)
  );

  dff_async_rst_n #(.WIDTH(STRB_WIDTH)) u_wstrb_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(cmd_capture),
    .d_i   (i_cmd_wstrb), .q_o(wstrb_q)
  );

  dff_async_rst_n #(.WIDTH(1)) u_rsp_write_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(rsp_capture),
    .d_i   (rsp_write_d), .q_o(rsp_write_q)
  );

  dff_async_rst_n #(.WIDTH(DATA_WIDTH)) u_rsp_rdata_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(rsp_capture),
    .d_i   (rsp_rdata_d), .q_o(rsp_rdata_q)
  );

  dff_async_rst_n #(.WIDTH(2)) u_rsp_resp_q (
    .clk_i (i_clock), .rst_ni(i_aresetn), .en_i(rsp_capture),
    .d_i   (rsp_resp_d), .q_o(rsp_resp_q)
  );

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign o_awaddr  = addr_q;
  assign o_awprot  = PROT;
  assign o_awvalid = awvalid_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_wvalid  = wvalid_q;
  assign o_bready  = bready_q;
  assign o_araddr  = addr_q;
  assign o_arprot  = PROT;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
module tb_axi4_lite_master;
  import axi4_lite_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [3:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_write;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [3:0]  o_awaddr, o_araddr;
  logic [2:0]  o_awprot, o_arprot;
  logic        o_awvalid, i_awready, o_wvalid, i_wready;
  logic [31:0] o_wdata, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;

  axi4_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: 4-word memory, configurable ready/valid delays and responses.
  bit          aw_early = 1'b1, w_early = 1'b1, ar_early = 1'b1;
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
  logic [31:0] mem [4];
  bit          aw_got = 0, w_got = 0, ar_got = 0;
  logic [3:0]  aw_a = '0, ar_a = '0, w_s = '0;
  logic [31:0] w_d = '0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int          b_hs = 0, r_hs = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (i_bvalid && o_bready) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
        aw_got = 0; w_got = 0; b_cnt = 0; b_hs++;
      end else if (aw_got && w_got) b_cnt++;
      if (i_rvalid && o_rready) begin
        ar_got = 0; r_cnt = 0; r_hs++;
      end else if (ar_got) r_cnt++;
      if (o_awvalid && i_awready) begin aw_got = 1; aw_a = o_awaddr; aw_cnt = 0; end
      else if (o_awvalid) aw_cnt++;
      if (o_wvalid && i_wready) begin w_got = 1; w_d = o_wdata; w_s = o_wstrb; w_cnt = 0; end
      else if (o_wvalid) w_cnt++;
      if (o_arvalid && i_arready) begin ar_got = 1; ar_a = o_araddr; ar_cnt = 0; end
      else if (o_arvalid) ar_cnt++;
    end
  end

  always @(negedge clk) begin
    i_awready = aw_early || (o_awvalid && aw_cnt >= aw_delay);
    i_wready  = w_early  || (o_wvalid  && w_cnt  >= w_delay);
    i_arready = ar_early || (o_arvalid && ar_cnt >= ar_delay);
    i_bvalid  = aw_got && w_got && (b_cnt >= b_delay);
    i_bresp   = i_bvalid ? cfg_bresp : 2'b00;
    i_rvalid  = ar_got && (r_cnt >= r_delay);
    i_rdata   = i_rvalid ? mem[ar_a[3:2]] : 32'h0;
    i_rresp   = i_rvalid ? cfg_rresp : 2'b00;
  end

  // Protocol monitor: a valid not accepted must persist with stable payload;
  // a valid that was accepted must drop (single outstanding).
  bit         pend_aw = 0, pend_w = 0, pend_ar = 0, hs_aw = 0, hs_w = 0, hs_ar = 0;
  logic [3:0] pend_awaddr, pend_araddr, pend_wstrb;
  logic [31:0] pend_wdata;

  always @(posedge clk) begin
    pend_aw = rst_n && o_awvalid && !i_awready;
    pend_w  = rst_n && o_wvalid  && !i_wready;
    pend_ar = rst_n && o_arvalid && !i_arready;
    hs_aw   = rst_n && o_awvalid && i_awready;
    hs_w    = rst_n && o_wvalid  && i_wready;
    hs_ar   = rst_n && o_arvalid && i_arready;
    pend_awaddr = o_awaddr; pend_araddr = o_araddr;
    pend_wdata  = o_wdata;  pend_wstrb  = o_wstrb;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pend_aw) begin chk("aw_hold_valid", o_awvalid, 1'b1); chk("aw_hold_addr", o_awaddr, pend_awaddr); end
      if (pend_w)  begin chk("w_hold_valid", o_wvalid, 1'b1); chk("w_hold_data", o_wdata, pend_wdata);
                         chk("w_hold_strb", o_wstrb, pend_wstrb); end
      if (pend_ar) begin chk("ar_hold_valid", o_arvalid, 1'b1); chk("ar_hold_addr", o_araddr, pend_araddr); end
      if (hs_aw) chk("aw_drop_after_hs", o_awvalid, 1'b0);
      if (hs_w)  chk("w_drop_after_hs", o_wvalid, 1'b0);
      if (hs_ar) chk("ar_drop_after_hs", o_arvalid, 1'b0);
    end
  end

  // Reference model: expected register-file contents at command level.
  logic [31:0] exp_mem [4];

  task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold, input bit poke, output int lat);
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    logic [3:0]  e_addr;
    int b0, r0, k;
    e_addr = {a[3:2], 2'b00};
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
    k = 0;
    while (!o_cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk("cmd_ready_idle", o_cmd_ready, 1'b1);
    b0 = b_hs; r0 = r_hs;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    chk("c1_cmd_busy", o_cmd_ready, 1'b0);
    chk("c1_awvalid", o_awvalid, wr);
    chk("c1_wvalid", o_wvalid, wr);
    chk("c1_arvalid", o_arvalid, !wr);
    if (wr) begin
      chk("c1_awaddr", o_awaddr, e_addr);
      chk("c1_wdata", o_wdata, d);
      chk("c1_wstrb", o_wstrb, s);
    end else begin
      chk("c1_araddr", o_araddr, e_addr);
    end
    if (wr) begin e_rdata = 32'h0; e_resp = cfg_bresp; end
    else    begin e_rdata = exp_mem[a[3:2]]; e_resp = cfg_rresp; end
    lat = 1;
    while (!o_rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    chk("rsp_valid_seen", o_rsp_valid, 1'b1);
    chk("rsp_write", o_rsp_write, wr);
    chk("rsp_rdata", o_rsp_rdata, e_rdata);
    chk("rsp_resp", o_rsp_resp, e_resp);
    chk("b_handshakes", b_hs - b0, wr ? 1 : 0);
    chk("r_handshakes", r_hs - r0, wr ? 0 : 1);
    if (wr) chk("slave_awaddr", aw_a, e_addr);
    else    chk("slave_araddr", ar_a, e_addr);
    if (wr)
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
    if (poke && hold > 0) begin
      i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 4'hC;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", o_rsp_valid, 1'b1);
      chk("hold_rsp_rdata", o_rsp_rdata, e_rdata);
      chk("hold_rsp_resp", o_rsp_resp, e_resp);
      chk("hold_rsp_write", o_rsp_write, wr);
      chk("hold_cmd_ready", o_cmd_ready, 1'b0);
      chk("hold_no_arvalid", o_arvalid, 1'b0);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("post_rsp_valid", o_rsp_valid, 1'b0);
    chk("post_cmd_ready", o_cmd_ready, 1'b1);
  endtask

  logic [1:0] resp_codes [4];
  int lat, b0;

  initial begin
    resp_codes[0] = RESP_OKAY;   resp_codes[1] = RESP_EXOKAY;
    resp_codes[2] = RESP_SLVERR; resp_codes[3] = RESP_DECERR;
    i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
    i_cmd_wstrb = '0; i_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin mem[i] = $urandom; exp_mem[i] = mem[i]; end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_awvalid", o_awvalid, 1'b0);
    chk("rst_wvalid", o_wvalid, 1'b0);
    chk("rst_arvalid", o_arvalid, 1'b0);
    chk("rst_bready", o_bready, 1'b0);
    chk("rst_rready", o_rready, 1'b0);
    chk("rst_rsp_valid", o_rsp_valid, 1'b0);
    chk("rst_awaddr", o_awaddr, 4'h0);
    chk("rst_wdata", o_wdata, 32'h0);
    chk("rst_wstrb", o_wstrb, 4'h0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    chk("rst_rsp_resp", o_rsp_resp, 2'b00);
    chk("rst_rsp_write", o_rsp_write, 1'b0);
    chk("prot_aw", o_awprot, 3'b000);
    chk("prot_ar", o_arprot, 3'b000);
    rst_n = 1'b1;

    // Zero-wait write and read-back: latency 3 for both.
    run_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 1'b0, lat);
    chk("lat_write_zero_wait", lat, 3);
    run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0, 1'b0, lat);
    chk("lat_read_zero_wait", lat, 3);

    // W accepted first, AW three cycles later.
    aw_early = 0; w_early = 0; aw_delay = 3; w_delay = 0;
    run_cmd(1'b1, 4'h8, 32'hA5A5_1234, 4'hF, 0, 1'b0, lat);
    // AW first, W later, partial strobes.
    aw_delay = 0; w_delay = 2;
    run_cmd(1'b1, 4'h9, 32'h7788_99AA, 4'b0101, 0, 1'b0, lat);
    run_cmd(1'b0, 4'h8, 32'h0, 4'h0, 0, 1'b0, lat);

    // Delayed AR and R with known data.
    mem[3] = 32'h12345678; exp_mem[3] = 32'h12345678;
    ar_early = 0; ar_delay = 2; r_delay = 4;
    run_cmd(1'b0, 4'hC, 32'h0, 4'h0, 0, 1'b0, lat);
    chk("read_0xC_data", o_rsp_rdata, 32'h12345678);

    // Unaligned read address and error response passthrough.
    ar_delay = 0; r_delay = 0; cfg_rresp = RESP_SLVERR;
    run_cmd(1'b0, 4'h3, 32'h0, 4'h0, 0, 1'b0, lat);
    cfg_rresp = RESP_OKAY; cfg_bresp = RESP_DECERR; b_delay = 1;
    run_cmd(1'b1, 4'h0, 32'hCAFE_F00D, 4'hF, 0, 1'b0, lat);
    cfg_bresp = RESP_OKAY; b_delay = 0;

    // Response back-pressure with a competing command presented meanwhile.
    run_cmd(1'b0, 4'h0, 32'h0, 4'h0, 5, 1'b1, lat);
    chk("after_hold_no_arvalid", o_arvalid, 1'b0);

    // Reset in the middle of a write with AW still pending.
    aw_early = 0; aw_delay = 8; w_early = 1;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 4'h4;
    i_cmd_wdata = 32'h0BAD_0BAD; i_cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    chk("abort_pre_awvalid", o_awvalid, 1'b1);
    b0 = b_hs;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_awvalid", o_awvalid, 1'b0);
    chk("abort_wvalid", o_wvalid, 1'b0);
    chk("abort_arvalid", o_arvalid, 1'b0);
    chk("abort_bready", o_bready, 1'b0);
    chk("abort_rsp_valid", o_rsp_valid, 1'b0);
    chk("abort_cmd_ready", o_cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", o_rsp_valid, 1'b0);
      chk("abort_idle_awvalid", o_awvalid, 1'b0);
      chk("abort_idle_ready", o_cmd_ready, 1'b1);
    end
    chk("abort_no_b", b_hs - b0, 0);
    aw_delay = 0; aw_early = 1;
    run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0, 1'b0, lat);

    // Randomized mix against the reference model.
    for (int n = 0; n < 30; n++) begin
      aw_early = 1'($urandom_range(0, 1)); w_early = 1'($urandom_range(0, 1));
      ar_early = 1'($urandom_range(0, 1));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      cfg_bresp = resp_codes[$urandom_range(0, 3)];
      cfg_rresp = resp_codes[$urandom_range(0, 3)];
      run_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
